// File: rtl/load_store_unit.sv
// Memory-access stage: turns an ALU-computed address into a single req/ack bus transaction,
// lane-aligns store data and sign/zero-extends load data, stalling the core until it completes.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic        fault_o,
  output logic [31:0] rdata_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StResp = 2'd2;
  localparam logic [1:0] StErr  = 2'd3;

  // Last counter value before giving up: bus_req is held exactly TIMEOUT_CYCLES cycles.
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, rdata_q;

  logic        illegal, misaligned, bad;
  logic        in_req, accept;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val, st_data;
  logic [3:0]  st_be;

  always_comb begin
    illegal = 1'b0;
    if (is_load_i == is_store_i) begin
      illegal = 1'b1;
    end else if (is_load_i) begin
      illegal = (funct3_i == 3'd3) || (funct3_i[2:1] == 2'b11);
    end else begin
      illegal = funct3_i[2] || (funct3_i[1:0] == 2'b11);
    end
    misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                 ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
    bad = illegal | misaligned;
  end

  assign accept = (state_q == StIdle) && start_i;
  assign in_req = (state_q == StReq);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = bad ? StErr : StReq;
          cnt_d   = 16'd0;
        end
      end
      StReq: begin
        // An ack in the timeout cycle still completes the access.
        if (bus_ack_i) begin
          state_d = StResp;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= 16'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= is_store_i;
        f3_q    <= funct3_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      if (in_req && bus_ack_i) begin
        rdata_q <= bus_rdata_i;
      end
    end
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte = rdata_q[7:0];
      2'd1:    ld_byte = rdata_q[15:8];
      2'd2:    ld_byte = rdata_q[23:16];
      default: ld_byte = rdata_q[31:24];
    endcase
    ld_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (f3_q[1:0])
      2'd0:    ld_val = {{24{~f3_q[2] & ld_byte[7]}}, ld_byte};
      2'd1:    ld_val = {{16{~f3_q[2] & ld_half[15]}}, ld_half};
      default: ld_val = rdata_q;
    endcase
    case (f3_q[1:0])
      2'd0: begin
        st_be   = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        st_be   = 4'b0011 << addr_q[1:0];
        st_data = {2{wdata_q[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = wdata_q;
      end
    endcase
  end

  // Illegal requests go straight to the fault pulse without holding the pipeline.
  assign stall_o     = (accept && !bad) || in_req;
  assign done_o      = (state_q == StResp) || (state_q == StErr);
  assign fault_o     = (state_q == StErr);
  assign rdata_o     = ((state_q == StResp) && !we_q) ? ld_val : 32'd0;
  assign bus_req_o   = in_req;
  assign bus_we_o    = in_req & we_q;
  assign bus_addr_o  = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus_be_o    = in_req ? st_be : 4'd0;
  assign bus_wdata_o = (in_req && we_q) ? st_data : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit built with a 4-cycle bus timeout.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, is_load = 1'b0, is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        stall, done, fault;
  logic [31:0] rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  int checks = 0;
  int errors = 0;

  int          nreq, stall_bad;
  logic        got_done, flt, we_s, stall_st, stall_dn, done_after;
  logic [31:0] rdat, bwd, badr;
  logic [3:0]  be_s;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .is_load_i(is_load), .is_store_i(is_store),
    .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata), .stall_o(stall), .done_o(done),
    .fault_o(fault), .rdata_o(rdata), .bus_req_o(bus_req), .bus_we_o(bus_we),
    .bus_addr_o(bus_addr), .bus_be_o(bus_be), .bus_wdata_o(bus_wdata), .bus_ack_i(bus_ack),
    .bus_rdata_i(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access; ack_at = index of the bus_req cycle that gets acked (0 = never).
  task automatic run(input logic ld, input logic st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int ack_at, input logic [31:0] rd);
    nreq = 0; stall_bad = 0; got_done = 1'b0; flt = 1'bx; rdat = 'x;
    be_s = 'x; we_s = 1'bx; bwd = 'x; badr = 'x; stall_dn = 1'bx;
    start = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = wd;
    #1;
    stall_st = stall;
    tick();
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        got_done = 1'b1; flt = fault; rdat = rdata; stall_dn = stall;
        break;
      end
      if (bus_req) begin
        nreq++;
        if (nreq == 1) begin
          be_s = bus_be; we_s = bus_we; bwd = bus_wdata; badr = bus_addr;
        end
        if (!stall) stall_bad++;
        if (nreq == ack_at) begin
          bus_ack = 1'b1; bus_rdata = rd;
        end
      end
      tick();
      bus_ack = 1'b0;
    end
    tick();
    done_after = done;
  endtask

  initial begin
    #12;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_req", {31'd0, bus_req}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // LW with three wait cycles; ack lands on the 4th (timeout) cycle and wins.
    run(1'b1, 1'b0, 3'd2, 32'h100, 32'd0, 4, 32'hDEADBEEF);
    chk("lw_done", {31'd0, got_done}, 32'd1);
    chk("lw_nreq", nreq, 32'd4);
    chk("lw_be", {28'd0, be_s}, 32'hF);
    chk("lw_addr", badr, 32'h100);
    chk("lw_we", {31'd0, we_s}, 32'd0);
    chk("lw_fault", {31'd0, flt}, 32'd0);
    chk("lw_rdata", rdat, 32'hDEADBEEF);
    chk("lw_stall_start", {31'd0, stall_st}, 32'd1);
    chk("lw_stall_req", stall_bad, 32'd0);
    chk("lw_stall_done", {31'd0, stall_dn}, 32'd0);
    chk("lw_done_pulse", {31'd0, done_after}, 32'd0);

    run(1'b1, 1'b0, 3'd0, 32'h103, 32'd0, 1, 32'h80FF1234);
    chk("lb_be", {28'd0, be_s}, 32'h8);
    chk("lb_addr", badr, 32'h100);
    chk("lb_rdata", rdat, 32'hFFFFFF80);
    run(1'b1, 1'b0, 3'd4, 32'h103, 32'd0, 1, 32'h80FF1234);
    chk("lbu_rdata", rdat, 32'h00000080);
    chk("lbu_nreq", nreq, 32'd1);
    run(1'b1, 1'b0, 3'd5, 32'h102, 32'd0, 2, 32'h80FF1234);
    chk("lhu_be", {28'd0, be_s}, 32'hC);
    chk("lhu_rdata", rdat, 32'h000080FF);
    run(1'b1, 1'b0, 3'd1, 32'h102, 32'd0, 1, 32'h80FF1234);
    chk("lh_hi_rdata", rdat, 32'hFFFF80FF);
    run(1'b1, 1'b0, 3'd1, 32'h100, 32'd0, 1, 32'h80FF1234);
    chk("lh_lo_rdata", rdat, 32'h00001234);
    chk("lh_lo_be", {28'd0, be_s}, 32'h3);

    run(1'b0, 1'b1, 3'd1, 32'h202, 32'h1234ABCD, 1, 32'hFFFFFFFF);
    chk("sh_we", {31'd0, we_s}, 32'd1);
    chk("sh_be", {28'd0, be_s}, 32'hC);
    chk("sh_wdata", bwd, 32'hABCDABCD);
    chk("sh_addr", badr, 32'h200);
    chk("sh_fault", {31'd0, flt}, 32'd0);
    chk("sh_rdata", rdat, 32'd0);
    run(1'b0, 1'b1, 3'd0, 32'h201, 32'h00000055, 1, 32'd0);
    chk("sb_be", {28'd0, be_s}, 32'h2);
    chk("sb_wdata", bwd, 32'h55555555);

    run(1'b1, 1'b0, 3'd2, 32'h101, 32'd0, 1, 32'd0);
    chk("lw_mis_nreq", nreq, 32'd0);
    chk("lw_mis_fault", {31'd0, flt}, 32'd1);
    chk("lw_mis_stall", {31'd0, stall_st}, 32'd0);
    chk("lw_mis_rdata", rdat, 32'd0);
    run(1'b0, 1'b1, 3'd1, 32'h203, 32'd0, 1, 32'd0);
    chk("sh_mis_nreq", nreq, 32'd0);
    chk("sh_mis_fault", {31'd0, flt}, 32'd1);
    chk("sh_mis_stall", {31'd0, stall_st}, 32'd0);
    run(1'b1, 1'b0, 3'd3, 32'h100, 32'd0, 1, 32'd0);
    chk("ld_f3_fault", {31'd0, flt}, 32'd1);
    run(1'b0, 1'b1, 3'd4, 32'h100, 32'd0, 1, 32'd0);
    chk("st_f3_fault", {31'd0, flt}, 32'd1);
    run(1'b1, 1'b1, 3'd2, 32'h100, 32'd0, 1, 32'd0);
    chk("both_ops_fault", {31'd0, flt}, 32'd1);

    run(1'b0, 1'b1, 3'd2, 32'h300, 32'h11223344, 0, 32'd0);
    chk("sw_to_nreq", nreq, 32'd4);
    chk("sw_to_fault", {31'd0, flt}, 32'd1);
    chk("sw_to_done", {31'd0, got_done}, 32'd1);
    chk("sw_to_stall_req", stall_bad, 32'd0);
    run(1'b0, 1'b1, 3'd2, 32'h300, 32'h11223344, 4, 32'd0);
    chk("sw_late_ack_fault", {31'd0, flt}, 32'd0);
    chk("sw_late_wdata", bwd, 32'h11223344);

    // Reset while the bus request is outstanding.
    start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h400;
    tick();
    start = 1'b0;
    chk("rst_pre_req", {31'd0, bus_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_req_drop", {31'd0, bus_req}, 32'd0);
    chk("rst_stall_drop", {31'd0, stall}, 32'd0);
    tick();
    chk("rst_no_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_idle_done", {31'd0, done}, 32'd0);
    run(1'b1, 1'b0, 3'd2, 32'h404, 32'd0, 1, 32'hCAFEF00D);
    chk("post_rst_fault", {31'd0, flt}, 32'd0);
    chk("post_rst_rdata", rdat, 32'hCAFEF00D);
    chk("post_rst_addr", badr, 32'h404);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
